perips_uart_txq: RTL
====================

# perips_uart_txq

Transmit queue and drain engine directly upstream of the UART peripheral. The CPU pushes bytes into a DEPTH-entry FIFO through a small register window. An internal bus-master FSM drives the UART's register port: it writes TXD, polls SR bit0 until the byte is done, then clears that flag with a write-1-to-clear. This lets software queue a string without polling the UART itself.

## Interface
- DEPTH, 16, FIFO entries; power of two, 2..256.
- UART_REG_SR, 8'h04, UART status register offset.
- UART_REG_TXD, 8'h10, UART transmit data register offset.
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- addr_i  in  8  CPU register offset.
- data_rd_i  in  1  CPU read strobe.
- data_we_i  in  1  CPU write strobe.
- data_i  in  DATA_BUS_WIDTH  CPU write data.
- data_o  out  DATA_BUS_WIDTH  CPU read data, registered, 1-cycle latency.
- uart_addr_o  out  8  UART register offset.
- uart_rd_o  out  1  UART read strobe.
- uart_we_o  out  1  UART write strobe.
- uart_data_o  out  DATA_BUS_WIDTH  UART write data.
- uart_data_i  in  DATA_BUS_WIDTH  UART read data, valid 1 cycle after uart_rd_o.
- irq_empty_o  out  1  level: enabled and FIFO empty and FSM IDLE.

## Operation
- Register map:
  - 0x00 CTRL: [0] enable (reset 1); [1] flush, write-only, self-clearing, reads 0.
  - 0x04 STAT, read-only except bit3:
    - [0] empty; [1] full; [2] busy (FSM not IDLE).
    - [3] overflow, sticky, W1C.
    - [4+:log2(DEPTH)+1] count.
  - 0x08 DATA: write pushes data_i[7:0]; reads 0.
  - Other offsets read 0; writes to them are ignored.
- Push rule: a push is accepted if not full, or if a pop happens in the same cycle. A rejected push sets overflow, and the FIFO is unchanged.
- Flush: rd/wr pointers and count go to 0 in 1 cycle. A flush wins over a push in the same cycle. A byte already popped still completes.
- FSM states, Moore outputs decoded from the state register:
  - IDLE: all strobes 0. If enable && !empty: pop head into byte_q, go to WR_TXD.
  - WR_TXD: uart_we_o=1, addr=UART_REG_TXD, data={24'b0,byte_q}. Go to RD_SR.
  - RD_SR: uart_rd_o=1, addr=UART_REG_SR. Go to WAIT_SR.
  - WAIT_SR: strobes 0. If uart_data_i[0] go to CLR_SR, else go to RD_SR.
  - CLR_SR: uart_we_o=1, addr=UART_REG_SR, data=32'h1. Go to IDLE.
- The SR clear write uses data 32'h1 so that bit0 is cleared and the rx flag (bit1) is preserved.
- Clearing enable mid-byte: the current byte still runs to CLR_SR. The FSM then stays in IDLE.
- Polls run back-to-back with no timeout. A stuck UART holds the FSM in the RD_SR/WAIT_SR loop until reset.

## Timing
- Reset values:
  - FSM IDLE; FIFO empty; overflow 0; enable 1.
  - data_o 0; uart strobes 0; uart_addr_o 0; uart_data_o 0.
  - irq_empty_o 1 (enabled, empty, IDLE).
- Push at edge N: visible in STAT.count at N+1. If the FSM is IDLE and enabled, the pop happens at edge N+1 and WR_TXD is asserted during cycle N+1..N+2.
- Minimum per-byte overhead is 5 cycles (IDLE, WR, RD, WAIT, CLR), plus each extra poll pair.
- Count width is log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- A CPU read returns the pre-edge state of the same cycle's write.

## Test plan
- Push 0x41, 0x42, 0x43 with a UART model that reports SR[0]=1 on the 3rd poll. Required response:
  - TXD writes occur in order 0x41, 0x42, 0x43.
  - Each is followed by exactly 3 RD_SR polls and one SR write of 0x1.
  - irq_empty_o rises after the last CLR_SR.
- With enable=0, push 17 bytes. Required response: STAT reads full=1, count=16, overflow=1. Then write STAT=0x8 and read overflow=0.
- Full FIFO, push coinciding with the IDLE pop. Required response: push accepted, count stays 16, overflow stays 0.
- Flush with 5 bytes queued while the FSM is in WAIT_SR. Required response: count=0 next cycle, the current byte completes, and no further TXD write occurs.
- Assert rst_n_i during RD_SR. Required response:
  - uart_rd_o drops 0 asynchronously.
  - All STAT fields return to reset values and CTRL reads 0x1.
- Push and flush in the same cycle. Required response: count=0 and the byte is not transmitted.

Source files
------------

// File: rtl/perips_uart_txq.sv
// UART transmit queue: CPU-facing byte FIFO plus a bus-master engine that
// writes each byte to the UART, polls its status until done, then W1C-clears it.
module perips_uart_txq #(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned DATA_BUS_WIDTH = 32,
  parameter logic [7:0]  UART_REG_SR    = 8'h04,
  parameter logic [7:0]  UART_REG_TXD   = 8'h10
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [7:0]                addr_i,
  input  logic                      data_rd_i,
  input  logic                      data_we_i,
  input  logic [DATA_BUS_WIDTH-1:0] data_i,
  output logic [DATA_BUS_WIDTH-1:0] data_o,
  output logic [7:0]                uart_addr_o,
  output logic                      uart_rd_o,
  output logic                      uart_we_o,
  output logic [DATA_BUS_WIDTH-1:0] uart_data_o,
  input  logic [DATA_BUS_WIDTH-1:0] uart_data_i,
  output logic                      irq_empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [7:0] REG_CTRL = 8'h00;
  localparam logic [7:0] REG_STAT = 8'h04;
  localparam logic [7:0] REG_DATA = 8'h08;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WR_TXD = 3'd1;
  localparam logic [2:0] S_RD_SR  = 3'd2;
  localparam logic [2:0] S_WAIT_SR = 3'd3;
  localparam logic [2:0] S_CLR_SR = 3'd4;

  logic [7:0]                mem_q [DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      enable_q, enable_d;
  logic                      ovf_q, ovf_d;
  logic [7:0]                byte_q, byte_d;
  logic [2:0]                state_q, state_d;
  logic [DATA_BUS_WIDTH-1:0] data_o_q, data_o_d;
  logic [7:0]                uart_addr_q, uart_addr_d;
  logic                      uart_rd_q, uart_rd_d;
  logic                      uart_we_q, uart_we_d;
  logic [DATA_BUS_WIDTH-1:0] uart_data_q, uart_data_d;
  logic                      irq_q, irq_d;

  logic                      ctrl_we_c, stat_we_c, push_req_c;
  logic                      flush_c, empty_c, full_c, pop_c, push_ok_c;
  logic [DATA_BUS_WIDTH-1:0] rdata_c;

  // Only the low byte of CPU data and SR bit0 carry meaning here.
  logic unused_bits;
  assign unused_bits = ^{data_i[DATA_BUS_WIDTH-1:8], uart_data_i[DATA_BUS_WIDTH-1:1]};

  assign ctrl_we_c  = data_we_i && (addr_i == REG_CTRL);
  assign stat_we_c  = data_we_i && (addr_i == REG_STAT);
  assign push_req_c = data_we_i && (addr_i == REG_DATA);
  assign flush_c    = ctrl_we_c && data_i[1];
  assign empty_c    = (count_q == '0);
  assign full_c     = (count_q == CNT_W'(DEPTH));
  // A flush landing on a pop opportunity suppresses the pop so no flushed byte escapes.
  assign pop_c      = (state_q == S_IDLE) && enable_q && !empty_c && !flush_c;
  assign push_ok_c  = push_req_c && (!full_c || pop_c) && !flush_c;

  // FIFO pointers, occupancy and control/status bits
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    enable_d = enable_q;
    if (flush_c) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_c);
    end
    if (push_req_c && !push_ok_c && !flush_c) ovf_d = 1'b1;
    else if (stat_we_c && data_i[3])          ovf_d = 1'b0;
    if (ctrl_we_c) enable_d = data_i[0];
  end

  // CPU read mux; reflects pre-edge state
  always_comb begin
    rdata_c = '0;
    case (addr_i)
      REG_CTRL: rdata_c[0] = enable_q;
      REG_STAT: begin
        rdata_c[0]          = empty_c;
        rdata_c[1]          = full_c;
        rdata_c[2]          = (state_q != S_IDLE);
        rdata_c[3]          = ovf_q;
        rdata_c[4 +: CNT_W] = count_q;
      end
      default: rdata_c = '0;
    endcase
    data_o_d = data_rd_i ? rdata_c : data_o_q;
  end

  // Drain FSM; UART port outputs are the registered decode of the next state
  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    uart_we_d   = 1'b0;
    uart_rd_d   = 1'b0;
    uart_addr_d = '0;
    uart_data_d = '0;
    case (state_q)
      S_IDLE: begin
        if (pop_c) begin
          byte_d  = mem_q[rd_ptr_q];
          state_d = S_WR_TXD;
        end
      end
      S_WR_TXD:  state_d = S_RD_SR;
      S_RD_SR:   state_d = S_WAIT_SR;
      S_WAIT_SR: state_d = uart_data_i[0] ? S_CLR_SR : S_RD_SR;
      S_CLR_SR:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    case (state_d)
      S_WR_TXD: begin
        uart_we_d   = 1'b1;
        uart_addr_d = UART_REG_TXD;
        uart_data_d = DATA_BUS_WIDTH'(byte_d);
      end
      S_RD_SR: begin
        uart_rd_d   = 1'b1;
        uart_addr_d = UART_REG_SR;
      end
      S_CLR_SR: begin
        // Writing only bit0 clears tx-done and leaves the rx flag alone.
        uart_we_d   = 1'b1;
        uart_addr_d = UART_REG_SR;
        uart_data_d = DATA_BUS_WIDTH'(1);
      end
      default: begin
        uart_we_d   = 1'b0;
        uart_rd_d   = 1'b0;
      end
    endcase
    irq_d = enable_d && (count_d == '0) && (state_d == S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      enable_q    <= 1'b1;
      ovf_q       <= 1'b0;
      byte_q      <= '0;
      state_q     <= S_IDLE;
      data_o_q    <= '0;
      uart_addr_q <= '0;
      uart_rd_q   <= 1'b0;
      uart_we_q   <= 1'b0;
      uart_data_q <= '0;
      irq_q       <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      enable_q    <= enable_d;
      ovf_q       <= ovf_d;
      byte_q      <= byte_d;
      state_q     <= state_d;
      data_o_q    <= data_o_d;
      uart_addr_q <= uart_addr_d;
      uart_rd_q   <= uart_rd_d;
      uart_we_q   <= uart_we_d;
      uart_data_q <= uart_data_d;
      irq_q       <= irq_d;
    end
  end

  // Storage array needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk_i) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= data_i[7:0];
  end

  assign data_o      = data_o_q;
  assign uart_addr_o = uart_addr_q;
  assign uart_rd_o   = uart_rd_q;
  assign uart_we_o   = uart_we_q;
  assign uart_data_o = uart_data_q;
  assign irq_empty_o = irq_q;

endmodule
